// File: rtl/id_ex_stage.sv
// Decode->Execute pipeline register with execute-stage operand forwarding.
// E-side control and operands are registered; ALU operands are muxed combinationally.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [RADDR-1:0] Rs1D,
  input  logic [RADDR-1:0] Rs2D,
  input  logic [RADDR-1:0] RdD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [1:0]       ResultSrcD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ResultW,
  output logic [XLEN-1:0]  SrcAE,
  output logic [XLEN-1:0]  SrcBE,
  output logic [XLEN-1:0]  WriteDataE,
  output logic [2:0]       ALUControlE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             ValidE,
  output logic [1:0]       ResultSrcE,
  output logic [RADDR-1:0] Rs1E,
  output logic [RADDR-1:0] Rs2E,
  output logic [RADDR-1:0] RdE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE
);

  localparam logic [RADDR-1:0] REG_ZERO = '0;

  logic             valid_d,       valid_q;
  logic [XLEN-1:0]  rd1_d,         rd1_q;
  logic [XLEN-1:0]  rd2_d,         rd2_q;
  logic [XLEN-1:0]  imm_ext_d,     imm_ext_q;
  logic [XLEN-1:0]  pc_d,          pc_q;
  logic [XLEN-1:0]  pc_plus4_d,    pc_plus4_q;
  logic [RADDR-1:0] rs1_d,         rs1_q;
  logic [RADDR-1:0] rs2_d,         rs2_q;
  logic [RADDR-1:0] rd_d,          rd_q;
  logic [2:0]       alu_control_d, alu_control_q;
  logic             alu_src_d,     alu_src_q;
  logic             reg_write_d,   reg_write_q;
  logic             mem_write_d,   mem_write_q;
  logic             branch_d,      branch_q;
  logic             jump_d,        jump_q;
  logic [1:0]       result_src_d,  result_src_q;

  logic [XLEN-1:0]  fwd_a;
  logic [XLEN-1:0]  fwd_b;

  // Flush beats stall: a bubble must replace the held instruction.
  always_comb begin
    valid_d       = valid_q;
    rd1_d         = rd1_q;
    rd2_d         = rd2_q;
    imm_ext_d     = imm_ext_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    alu_control_d = alu_control_q;
    alu_src_d     = alu_src_q;
    reg_write_d   = reg_write_q;
    mem_write_d   = mem_write_q;
    branch_d      = branch_q;
    jump_d        = jump_q;
    result_src_d  = result_src_q;
    if (FlushE) begin
      valid_d       = 1'b0;
      rd1_d         = '0;
      rd2_d         = '0;
      imm_ext_d     = '0;
      pc_d          = '0;
      pc_plus4_d    = '0;
      rs1_d         = '0;
      rs2_d         = '0;
      rd_d          = '0;
      alu_control_d = '0;
      alu_src_d     = 1'b0;
      reg_write_d   = 1'b0;
      mem_write_d   = 1'b0;
      branch_d      = 1'b0;
      jump_d        = 1'b0;
      result_src_d  = '0;
    end else if (!StallE) begin
      valid_d       = ValidD;
      rd1_d         = RD1D;
      rd2_d         = RD2D;
      imm_ext_d     = ImmExtD;
      pc_d          = PCD;
      pc_plus4_d    = PCPlus4D;
      rs1_d         = Rs1D;
      rs2_d         = Rs2D;
      rd_d          = RdD;
      alu_control_d = ALUControlD;
      alu_src_d     = ALUSrcD;
      // x0 is hardwired zero, so its writes are dropped here once.
      reg_write_d   = RegWriteD && (RdD != REG_ZERO);
      mem_write_d   = MemWriteD;
      branch_d      = BranchD;
      jump_d        = JumpD;
      result_src_d  = ResultSrcD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_ext_q     <= '0;
      pc_q          <= '0;
      pc_plus4_q    <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_control_q <= '0;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      result_src_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_ext_q     <= imm_ext_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      reg_write_q   <= reg_write_d;
      mem_write_q   <= mem_write_d;
      branch_q      <= branch_d;
      jump_q        <= jump_d;
      result_src_q  <= result_src_d;
    end
  end

  // Forward selects are live every cycle, including during stall and reset.
  always_comb begin
    fwd_a = rd1_q;
    unique case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = rd1_q;
    endcase
  end

  always_comb begin
    fwd_b = rd2_q;
    unique case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = rd2_q;
    endcase
  end

  assign SrcAE       = fwd_a;
  assign WriteDataE  = fwd_b;
  assign SrcBE       = alu_src_q ? imm_ext_q : fwd_b;
  assign ALUControlE = alu_control_q;
  assign RegWriteE   = reg_write_q;
  assign MemWriteE   = mem_write_q;
  assign BranchE     = branch_q;
  assign JumpE       = jump_q;
  assign ValidE      = valid_q;
  assign ResultSrcE  = result_src_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc_plus4_q;
  assign ImmExtE     = imm_ext_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference E-register model feeding an
// expected-output queue, compared against the DUT after each capture or forward change.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  typedef struct packed {
    logic [XLEN-1:0]  src_a;
    logic [XLEN-1:0]  src_b;
    logic [XLEN-1:0]  wdata;
    logic [2:0]       aluc;
    logic             regw;
    logic             memw;
    logic             br;
    logic             jmp;
    logic             valid;
    logic [1:0]       rsrc;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  imm;
  } exp_t;

  typedef struct packed {
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc4;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic [2:0]       aluc;
    logic             alu_src;
    logic             regw;
    logic             memw;
    logic             br;
    logic             jmp;
    logic             valid;
    logic [1:0]       rsrc;
  } model_t;

  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             StallE, FlushE, ValidD;
  logic [XLEN-1:0]  RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [RADDR-1:0] Rs1D, Rs2D, RdD;
  logic [2:0]       ALUControlD;
  logic             ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]       ResultSrcD, ForwardAE, ForwardBE;
  logic [XLEN-1:0]  ALUResultM, ResultW;
  logic [XLEN-1:0]  SrcAE, SrcBE, WriteDataE;
  logic [2:0]       ALUControlE;
  logic             RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
  logic [1:0]       ResultSrcE;
  logic [RADDR-1:0] Rs1E, Rs2E, RdE;
  logic [XLEN-1:0]  PCE, PCPlus4E, ImmExtE;

  id_ex_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ResultSrcD(ResultSrcD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .WriteDataE(WriteDataE), .ALUControlE(ALUControlE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE),
    .ResultSrcE(ResultSrcE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE)
  );

  // ---------------- scoreboard / model ----------------
  logic [EXP_W-1:0] exp_q[$];
  model_t m;
  int checks = 0;
  int failures = 0;

  function automatic model_t capture();
    model_t c;
    c.rd1     = RD1D;
    c.rd2     = RD2D;
    c.imm     = ImmExtD;
    c.pc      = PCD;
    c.pc4     = PCPlus4D;
    c.rs1     = Rs1D;
    c.rs2     = Rs2D;
    c.rd      = RdD;
    c.aluc    = ALUControlD;
    c.alu_src = ALUSrcD;
    c.regw    = RegWriteD && (RdD != 5'd0);
    c.memw    = MemWriteD;
    c.br      = BranchD;
    c.jmp     = JumpD;
    c.valid   = ValidD;
    c.rsrc    = ResultSrcD;
    return c;
  endfunction

  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel, input logic [XLEN-1:0] reg_v);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return ALUResultM;
    return reg_v;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [XLEN-1:0] fb;
    fb      = fwd_sel(ForwardBE, m.rd2);
    e.src_a = fwd_sel(ForwardAE, m.rd1);
    e.wdata = fb;
    e.src_b = m.alu_src ? m.imm : fb;
    e.aluc  = m.aluc;
    e.regw  = m.regw;
    e.memw  = m.memw;
    e.br    = m.br;
    e.jmp   = m.jmp;
    e.valid = m.valid;
    e.rsrc  = m.rsrc;
    e.rs1   = m.rs1;
    e.rs2   = m.rs2;
    e.rd    = m.rd;
    e.pc    = m.pc;
    e.pc4   = m.pc4;
    e.imm   = m.imm;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o = {SrcAE, SrcBE, WriteDataE, ALUControlE, RegWriteE, MemWriteE, BranchE, JumpE,
         ValidE, ResultSrcE, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ImmExtE};
    return o;
  endfunction

  // An empty queue yields all-X, which can never match a real observation.
  function automatic exp_t pop_exp();
    exp_t e;
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic randomize_d();
    ValidD      = 1'($urandom_range(0, 1));
    RD1D        = $urandom;
    RD2D        = $urandom;
    ImmExtD     = $urandom;
    PCD         = $urandom;
    PCPlus4D    = $urandom;
    Rs1D        = 5'($urandom_range(0, 31));
    Rs2D        = 5'($urandom_range(0, 31));
    RdD         = 5'($urandom_range(0, 31));
    ALUControlD = 3'($urandom_range(0, 7));
    ALUSrcD     = 1'($urandom_range(0, 1));
    RegWriteD   = 1'($urandom_range(0, 1));
    MemWriteD   = 1'($urandom_range(0, 1));
    BranchD     = 1'($urandom_range(0, 1));
    JumpD       = 1'($urandom_range(0, 1));
    ResultSrcD  = 2'($urandom_range(0, 3));
  endtask

  // Update the model for the coming edge, queue the expectation, then cross the edge.
  task automatic step();
    if (FlushE) m = '0;
    else if (!StallE) m = capture();
    exp_q.push_back(predict());
    @(posedge clk);
    #1;
  endtask

  // Combinational-only change: queue the expectation and let it settle.
  task automatic settle();
    exp_q.push_back(predict());
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t obs, exp;
    randomize_d();
    ValidD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
    StallE = 1'b0; FlushE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUResultM = 32'h0000_0055; ResultW = 32'h0000_0066;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m = '0;
    settle();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_all_zero got=%h exp=%h", obs, exp); end
    checks++;
    if (ValidE !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ValidE); end

    ForwardAE = 2'b10;
    settle();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_fwd_m got=%h exp=%h", obs, exp); end
    ForwardAE = 2'b00;

    rst_n = 1'b1;
    RD1D = 32'd5; RD2D = 32'd7; ALUSrcD = 1'b0; ALUControlD = 3'b001;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL first_load got=%h exp=%h", obs, exp); end
    checks++;
    if (SrcAE !== 32'd5 || SrcBE !== 32'd7 || ALUControlE !== 3'b001) begin
      failures++;
      $display("FAIL first_load_ops got=%h/%h/%b exp=5/7/001", SrcAE, SrcBE, ALUControlE);
    end
  endtask

  task automatic test_imm_select();
    exp_t obs, exp;
    randomize_d();
    ALUSrcD = 1'b1; ImmExtD = 32'hFFFF_FFF0; RD2D = 32'd3;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL imm_select got=%h exp=%h", obs, exp); end
    checks++;
    if (SrcBE !== 32'hFFFF_FFF0 || WriteDataE !== 32'd3) begin
      failures++;
      $display("FAIL imm_select_ops got=%h/%h exp=fffffff0/00000003", SrcBE, WriteDataE);
    end
  endtask

  task automatic test_forwarding();
    exp_t obs, exp;
    randomize_d();
    ALUSrcD = 1'b0;
    step();
    void'(pop_exp());
    ForwardAE = 2'b10; ALUResultM = 32'h0000_1234;
    ForwardBE = 2'b01; ResultW = 32'h0000_ABCD;
    settle();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL fwd_m_w got=%h exp=%h", obs, exp); end
    checks++;
    if (SrcAE !== 32'h1234 || SrcBE !== 32'hABCD || WriteDataE !== 32'hABCD) begin
      failures++;
      $display("FAIL fwd_m_w_ops got=%h/%h/%h exp=1234/abcd/abcd", SrcAE, SrcBE, WriteDataE);
    end
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    settle();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL fwd_reserved got=%h exp=%h", obs, exp); end
    ForwardAE = 2'b01; ForwardBE = 2'b10;
    settle();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL fwd_w_m got=%h exp=%h", obs, exp); end
    ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  task automatic test_stall_flush();
    exp_t obs, exp;
    randomize_d();
    RegWriteD = 1'b1; RdD = 5'd12; ValidD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b1;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL pre_stall got=%h exp=%h", obs, exp); end
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_d();
      step();
      obs = observe(); exp = pop_exp(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs, exp); end
    end
    FlushE = 1'b1;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL flush_over_stall got=%h exp=%h", obs, exp); end
    checks++;
    if ({RegWriteE, MemWriteE, BranchE, JumpE, ValidE} !== 5'b0) begin
      failures++;
      $display("FAIL flush_ctrl got=%b exp=00000", {RegWriteE, MemWriteE, BranchE, JumpE, ValidE});
    end
    StallE = 1'b0; FlushE = 1'b0;
  endtask

  task automatic test_x0_write();
    exp_t obs, exp;
    randomize_d();
    RegWriteD = 1'b1; RdD = 5'd0;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL x0_write got=%h exp=%h", obs, exp); end
    checks++;
    if (RegWriteE !== 1'b0) begin failures++; $display("FAIL x0_regwrite got=%b exp=0", RegWriteE); end
    RdD = 5'd5;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL x5_write got=%h exp=%h", obs, exp); end
    checks++;
    if (RegWriteE !== 1'b1 || RdE !== 5'd5) begin
      failures++;
      $display("FAIL x5_regwrite got=%b/%0d exp=1/5", RegWriteE, RdE);
    end
  endtask

  task automatic test_back_to_back();
    exp_t obs, exp;
    for (int i = 0; i < 40; i++) begin
      randomize_d();
      StallE     = ($urandom_range(0, 3) == 0);
      FlushE     = ($urandom_range(0, 7) == 0);
      ForwardAE  = 2'($urandom_range(0, 3));
      ForwardBE  = 2'($urandom_range(0, 3));
      ALUResultM = $urandom;
      ResultW    = $urandom;
      step();
      obs = observe(); exp = pop_exp(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, obs, exp); end
    end
    StallE = 1'b0; FlushE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  task automatic test_async_reset();
    exp_t obs, exp;
    randomize_d();
    ValidD = 1'b1; RD1D = 32'hDEAD_BEEF;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL pre_async got=%h exp=%h", obs, exp); end
    #3;
    rst_n = 1'b0;
    #1;
    m = '0;
    settle();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL async_reset_mid got=%h exp=%h", obs, exp); end
    #2;
    rst_n = 1'b1;
    randomize_d();
    ValidD = 1'b1;
    step();
    obs = observe(); exp = pop_exp(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL post_reset_load got=%h exp=%h", obs, exp); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    m = '0;
    test_reset();
    test_imm_select();
    test_forwarding();
    test_stall_flush();
    test_x0_write();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
